inst_fetch: RTL and testbench

//   Instruction-fetch stage directly upstream of the byte-serial memory controller.

---
 rtl/inst_fetch.sv | 202 ++++++++++++++++++++
 tb/tb_inst_fetch.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction-fetch stage in front of the byte-serial memory controller
//
// Purpose:
//   Requests instruction words from the memory controller and buffers them in
//   a small queue. Decode takes {pc, inst} from the queue over a valid/ready
//   handshake. Branch/jump redirects flush the queue. A redirect that arrives
//   while a fetch is in flight lets that fetch finish at its old address and
//   then throws the word away.
//
// Ports:
//   clk           clock, all state updates on posedge
//   rst           asynchronous active-low reset
//   pc_o          fetch address, held stable while a fetch is outstanding
//   pc_enable_o   fetch request to the memory controller
//   ram_done_i    one-cycle completion pulse from the controller
//   mpc_i         1 = controller is serving a data access; ram_done_i not ours
//   ram_data_i    assembled word, valid with ram_done_i
//   jump_i        redirect request (one cycle)
//   jump_addr_i   redirect target (bits [1:0] forced to 0)
//   id_ready_i    decode accepts the queue head this cycle
//   inst_valid_o  queue head valid
//   inst_o        queue head instruction
//   inst_pc_o     queue head PC

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  output logic        pc_enable_o,
  input  logic        ram_done_i,
  input  logic        mpc_i,
  input  logic [31:0] ram_data_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic        id_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  localparam int             AW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int             CW    = AW + 1;
  localparam logic [CW-1:0]  QFULL = CW'(QDEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   pc_q;
  logic          pc_en_q;

  logic [31:0]   mem_inst_q [QDEPTH];
  logic [31:0]   mem_pc_q   [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q;
  logic [31:0]   inst_q;
  logic [31:0]   inst_pc_q;

  logic [31:0]   target;
  logic          fetch_done;
  logic          push;
  logic          pop;
  logic          slot_free;
  logic          head_bypass;
  logic [31:0]   head_inst_d;
  logic [31:0]   head_pc_d;

  assign target     = {jump_addr_i[31:2], 2'b00};
  // ram_done_i during a data-side transaction belongs to the data path.
  assign fetch_done = ram_done_i && !mpc_i && (state_q != IDLE);
  // Only REQ pushes; a word completing in DROP or alongside a jump is stale.
  assign push       = (state_q == REQ) && fetch_done && !jump_i;
  assign pop        = valid_q && id_ready_i && !jump_i;
  // count_d already folds in this cycle's push and pop, so it equals
  // queue count + outstanding fetch - pop for the decision at this edge.
  assign slot_free  = (count_d < QFULL);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (jump_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // The new head is the word being written when no older entry remains ahead of it.
  assign head_bypass = push && (wr_ptr_q == rd_ptr_d);
  assign head_inst_d = head_bypass ? ram_data_i : mem_inst_q[rd_ptr_d];
  assign head_pc_d   = head_bypass ? fetch_pc_q : mem_pc_q[rd_ptr_d];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_inst_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      if (push) begin
        mem_inst_q[wr_ptr_q] <= ram_data_i;
        mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= (count_d != '0);
      inst_q    <= head_inst_d;
      inst_pc_q <= head_pc_d;
    end
  end

  // pc_q is separate from fetch_pc_q so DROP can keep presenting the old
  // address to the controller while fetch_pc_q already holds the target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      pc_en_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (jump_i) begin
            state_q    <= REQ;
            fetch_pc_q <= target;
            pc_q       <= target;
            pc_en_q    <= 1'b1;
          end else if (slot_free) begin
            state_q <= REQ;
            pc_q    <= fetch_pc_q;
            pc_en_q <= 1'b1;
          end
        end
        REQ: begin
          if (fetch_done) begin
            if (jump_i) begin
              state_q    <= REQ;
              fetch_pc_q <= target;
              pc_q       <= target;
              pc_en_q    <= 1'b1;
            end else begin
              fetch_pc_q <= fetch_pc_q + 32'd4;
              pc_q       <= fetch_pc_q + 32'd4;
              if (slot_free) begin
                state_q <= REQ;
                pc_en_q <= 1'b1;
              end else begin
                state_q <= IDLE;
                pc_en_q <= 1'b0;
              end
            end
          end else if (jump_i) begin
            state_q    <= DROP;
            fetch_pc_q <= target;
          end
        end
        DROP: begin
          if (fetch_done) begin
            state_q    <= REQ;
            pc_en_q    <= 1'b1;
            fetch_pc_q <= jump_i ? target : fetch_pc_q;
            pc_q       <= jump_i ? target : fetch_pc_q;
          end else if (jump_i) begin
            fetch_pc_q <= target;
          end
        end
        default: begin
          state_q <= IDLE;
          pc_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o         = pc_q;
  assign pc_enable_o  = pc_en_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch

module tb_inst_fetch;

  localparam int QDEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_o;
  logic        pc_enable_o;
  logic        ram_done_i;
  logic        mpc_i;
  logic [31:0] ram_data_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        id_ready_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_o         (pc_o),
    .pc_enable_o  (pc_enable_o),
    .ram_done_i   (ram_done_i),
    .mpc_i        (mpc_i),
    .ram_data_i   (ram_data_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .id_ready_i   (id_ready_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a * 32'd3 + 32'h13;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: compares every handshake against the expected order.
  always @(negedge clk) begin
    if (rst) begin
      if (jump_i) begin
        sb.delete();
      end else if (inst_valid_o && id_ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got pc=%h inst=%h, want no entry", inst_pc_o, inst_o);
        end else begin
          logic [63:0] exp;
          exp = sb.pop_front();
          if ({inst_pc_o, inst_o} !== exp) begin
            errors++;
            $display("FAIL pop_entry: got pc=%h inst=%h, want pc=%h inst=%h",
                     inst_pc_o, inst_o, exp[63:32], exp[31:0]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && dut.push && (int'(dut.count_q) >= QDEPTH)) begin
      errors++;
      $display("FAIL push_full: got push with count=%0d, want no push when full", dut.count_q);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic mem_done(input logic [31:0] a, input logic jmp, input logic [31:0] jaddr,
                          input logic expect_push);
    checks++;
    if (pc_o !== a || pc_enable_o !== 1'b1) begin
      errors++;
      $display("FAIL done_addr: got pc_o=%h en=%b, want pc_o=%h en=1", pc_o, pc_enable_o, a);
    end
    ram_data_i  = memw(a);
    ram_done_i  = 1'b1;
    mpc_i       = 1'b0;
    jump_i      = jmp;
    jump_addr_i = jaddr;
    if (expect_push) sb.push_back({a, memw(a)});
    cyc();
    ram_done_i  = 1'b0;
    jump_i      = 1'b0;
    ram_data_i  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ram_done_i = 0; mpc_i = 0; ram_data_i = '0;
    jump_i = 0; jump_addr_i = '0; id_ready_i = 1'b1;
    #2;
    checks++;
    if ({pc_enable_o, inst_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got en=%b valid=%b, want 0 0", pc_enable_o, inst_valid_o);
    end
    checks++;
    if (pc_o !== 32'h0 || inst_o !== 32'h0 || inst_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: got pc=%h inst=%h ipc=%h, want 0 0 0", pc_o, inst_o, inst_pc_o);
    end
    cyc(); cyc();
    checks++;
    if (pc_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got en=%b, want 0", pc_enable_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_fetch();
    cyc();
    checks++;
    if (pc_enable_o !== 1'b1 || pc_o !== 32'h0) begin
      errors++;
      $display("FAIL t1_first_req: got en=%b pc=%h, want 1 00000000", pc_enable_o, pc_o);
    end
    repeat (4) cyc();
    checks++;
    if (pc_enable_o !== 1'b1 || pc_o !== 32'h0 || inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t1_waiting: got en=%b pc=%h valid=%b, want 1 0 0", pc_enable_o, pc_o, inst_valid_o);
    end
    mem_done(32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (inst_valid_o !== 1'b1 || inst_o !== 32'h13 || inst_pc_o !== 32'h0 || pc_o !== 32'h4) begin
      errors++;
      $display("FAIL t1_output: got valid=%b inst=%h ipc=%h pc=%h, want 1 00000013 0 4",
               inst_valid_o, inst_o, inst_pc_o, pc_o);
    end
    cyc();
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t1_one_cycle: got valid=%b, want 0", inst_valid_o);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    sb.delete();
    rst = 1'b1;
  endtask

  task automatic test_backpressure();
    do_reset();
    id_ready_i = 1'b0;
    cyc();
    mem_done(32'h0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (pc_enable_o !== 1'b1 || pc_o !== 32'h4) begin
      errors++;
      $display("FAIL t2_second_req: got en=%b pc=%h, want 1 4", pc_enable_o, pc_o);
    end
    mem_done(32'h4, 1'b0, 32'h0, 1'b1);
    checks++;
    if (pc_enable_o !== 1'b0) begin
      errors++;
      $display("FAIL t2_stall: got en=%b, want 0", pc_enable_o);
    end
    // A third completion pulse while no request is outstanding must be ignored.
    ram_data_i = 32'hDEAD_BEEF; ram_done_i = 1'b1;
    cyc();
    ram_done_i = 1'b0;
    cyc();
    checks++;
    if (pc_enable_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL t2_full: got en=%b valid=%b ipc=%h, want 0 1 0", pc_enable_o, inst_valid_o, inst_pc_o);
    end
    id_ready_i = 1'b1;
    cyc();
    checks++;
    if (pc_enable_o !== 1'b1 || pc_o !== 32'h8 || inst_pc_o !== 32'h4) begin
      errors++;
      $display("FAIL t2_resume: got en=%b pc=%h ipc=%h, want 1 8 4", pc_enable_o, pc_o, inst_pc_o);
    end
    cyc();
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t2_drained: got valid=%b, want 0", inst_valid_o);
    end
  endtask

  task automatic test_jump_in_flight();
    jump_i = 1'b1; jump_addr_i = 32'h103;
    cyc();
    jump_i = 1'b0;
    checks++;
    if (pc_o !== 32'h8 || pc_enable_o !== 1'b1) begin
      errors++;
      $display("FAIL t3_hold_1: got pc=%h en=%b, want 8 1", pc_o, pc_enable_o);
    end
    cyc();
    checks++;
    if (pc_o !== 32'h8) begin
      errors++;
      $display("FAIL t3_hold_2: got pc=%h, want 8", pc_o);
    end
    mem_done(32'h8, 1'b0, 32'h0, 1'b0);
    checks++;
    if (pc_o !== 32'h100 || pc_enable_o !== 1'b1 || inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t3_target: got pc=%h en=%b valid=%b, want 100 1 0", pc_o, pc_enable_o, inst_valid_o);
    end
    mem_done(32'h100, 1'b0, 32'h0, 1'b1);
    cyc(); cyc();
  endtask

  task automatic test_jump_with_done();
    id_ready_i = 1'b0;
    mem_done(32'h104, 1'b0, 32'h0, 1'b1);
    checks++;
    if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h104) begin
      errors++;
      $display("FAIL t4_queued: got valid=%b ipc=%h, want 1 104", inst_valid_o, inst_pc_o);
    end
    mem_done(32'h108, 1'b1, 32'h202, 1'b0);
    checks++;
    if (inst_valid_o !== 1'b0 || pc_enable_o !== 1'b1 || pc_o !== 32'h200) begin
      errors++;
      $display("FAIL t4_redirect: got valid=%b en=%b pc=%h, want 0 1 200", inst_valid_o, pc_enable_o, pc_o);
    end
    id_ready_i = 1'b1;
    mem_done(32'h200, 1'b0, 32'h0, 1'b1);
    cyc(); cyc();
  endtask

  task automatic test_mpc();
    ram_data_i = 32'hBAD0_0000; ram_done_i = 1'b1; mpc_i = 1'b1;
    cyc();
    ram_done_i = 1'b0; mpc_i = 1'b0;
    checks++;
    if (pc_o !== 32'h204 || pc_enable_o !== 1'b1 || inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t5_data_side: got pc=%h en=%b valid=%b, want 204 1 0", pc_o, pc_enable_o, inst_valid_o);
    end
    cyc();
    mem_done(32'h204, 1'b0, 32'h0, 1'b1);
    checks++;
    if (inst_valid_o !== 1'b1 || pc_o !== 32'h208) begin
      errors++;
      $display("FAIL t5_push: got valid=%b pc=%h, want 1 208", inst_valid_o, pc_o);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) mem_done(32'h208 + 32'(4 * i), 1'b0, 32'h0, 1'b1);
    checks++;
    if (pc_o !== 32'h218 || pc_enable_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pc: got pc=%h en=%b, want 218 1", pc_o, pc_enable_o);
    end
    cyc(); cyc();
  endtask

  task automatic test_reset_mid_fetch();
    mem_done(32'h218, 1'b1, 32'h40, 1'b0);
    cyc();
    checks++;
    if (pc_o !== 32'h40 || pc_enable_o !== 1'b1) begin
      errors++;
      $display("FAIL t6_pre: got pc=%h en=%b, want 40 1", pc_o, pc_enable_o);
    end
    ram_data_i = memw(32'h40); ram_done_i = 1'b1;
    rst = 1'b0;
    #1;
    checks++;
    if (pc_enable_o !== 1'b0 || pc_o !== 32'h0 || inst_valid_o !== 1'b0 ||
        inst_o !== 32'h0 || inst_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL t6_async: got en=%b pc=%h valid=%b inst=%h ipc=%h, want all 0",
               pc_enable_o, pc_o, inst_valid_o, inst_o, inst_pc_o);
    end
    cyc();
    ram_done_i = 1'b0; ram_data_i = '0;
    cyc();
    sb.delete();
    rst = 1'b1;
    cyc();
    checks++;
    if (pc_enable_o !== 1'b1 || pc_o !== 32'h0 || inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL t6_restart: got en=%b pc=%h valid=%b, want 1 0 0", pc_enable_o, pc_o, inst_valid_o);
    end
    mem_done(32'h0, 1'b0, 32'h0, 1'b1);
    cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_jump_in_flight();
    test_jump_with_done();
    test_mpc();
    test_back_to_back();
    test_reset_mid_fetch();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: got %0d pending entries, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
